// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between NUM_REQ requesters.
// Latency: request captured at edge E0 (valid from E0); completion pulses the cycle after ready is sampled.
// Backpressure: one transaction in flight; requesters hold req_valid/payload until their req_ready pulse.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN (aborts after TIMEOUT unacknowledged BUSY cycles).
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_wr_rd,
  input  logic [NUM_REQ*`ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*`WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [`WIDTH-1:0]              rsp_rdata,
  output logic [1:0]                     grant_id,
  output logic                           err,
  output logic                           valid,
  output logic                           wr_rd,
  output logic [`ADDR_WIDTH-1:0]         addr,
  output logic [`WIDTH-1:0]              wdata,
  input  logic                           ready,
  input  logic [`WIDTH-1:0]              rdata
);

  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `WIDTH;

  // Elaboration-time guard on the supported configuration range.
  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
    $error("mem_arbiter: NUM_REQ must be 2..4 and TIMEOUT 1..255");
  end

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DW-1:0]      rsp_rdata_q;
  logic [DW-1:0]      wdata_q;
  logic [AW-1:0]      addr_q;
  logic [1:0]         grant_q;
  logic [1:0]         last_q;
  logic               valid_q;
  logic               wr_rd_q;

  // Padded to 4 bits so a 2-bit requester index always selects in range.
  logic [3:0]         elig_pad;
  logic [3:0]         wr_rd_pad;
  logic [1:0]         win_d;
  logic               win_vld_d;
  logic [NUM_REQ-1:0] gnt_oh;

  // A requester being told req_ready this cycle is retiring; never re-grant it on this edge.
  assign elig_pad  = 4'(req_valid & ~req_ready_q);
  assign wr_rd_pad = 4'(req_wr_rd);
  assign gnt_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;

  // Round-robin pick: first eligible requester searching upward from last+1, wrapping.
  always_comb begin
    win_vld_d = 1'b0;
    win_d     = 2'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_vld_d && elig_pad[2'((int'(last_q) + k) % NUM_REQ)]) begin
        win_vld_d = 1'b1;
        win_d     = 2'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;
`endif

  // Arbiter FSM: capture in IDLE, hold the memory request in BUSY until ready (or watchdog).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      wdata_q     <= '0;
      addr_q      <= '0;
      grant_q     <= 2'd0;
      last_q      <= 2'(NUM_REQ - 1);
      valid_q     <= 1'b0;
      wr_rd_q     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      // Completion indications are single-cycle pulses.
      req_ready_q <= '0;
      rsp_valid_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (win_vld_d) begin
            wr_rd_q <= wr_rd_pad[win_d];
            addr_q  <= req_addr[int'(win_d)*AW +: AW];
            wdata_q <= req_wdata[int'(win_d)*DW +: DW];
            valid_q <= 1'b1;
            grant_q <= win_d;
            state_q <= S_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
          end
        end
        S_BUSY: begin
          if (ready) begin
            valid_q     <= 1'b0;
            req_ready_q <= gnt_oh;
            if (!wr_rd_q) begin
              rsp_rdata_q <= rdata;
              rsp_valid_q <= gnt_oh;
            end
            last_q  <= grant_q;
            state_q <= S_IDLE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          // Abort on the edge where the stall count would reach TIMEOUT; a same-edge ready wins above.
          else if (cnt_q == 8'(TIMEOUT - 1)) begin
            valid_q     <= 1'b0;
            req_ready_q <= gnt_oh;
            err_q       <= 1'b1;
            last_q      <= grant_q;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign grant_id  = grant_q;
  assign valid     = valid_q;
  assign wr_rd     = wr_rd_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus a randomized queue-driven run.
// Expected grants, payloads and read data come from a transaction-level model (queues + memory array).
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module tb_mem_arbiter;
  localparam int N  = 2;
  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `WIDTH;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid, req_wr_rd, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, wdata, rdata;
  logic [1:0]      grant_id;
  logic            err, valid, wr_rd, ready;
  logic [AW-1:0]   addr;

  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } txn_t;

  txn_t          qs[N][$];
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            last_m;
  int            total = 0;
  int            bad   = 0;

  mem_arbiter #(.NUM_REQ(N), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr_rd(req_wr_rd), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .grant_id(grant_id), .err(err),
    .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr_rd[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Spec rule: first requester with outstanding work after 'last', wrapping.
  function automatic int rr_pick(input int last);
    for (int k = 1; k <= N; k++) begin
      if (qs[(last + k) % N].size() > 0) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    ready = 1'b0;
    rdata = '0;
    req_valid = 2'b11;
    set_req(0, 1'b0, 8'h11, 8'h01);
    set_req(1, 1'b0, 8'h22, 8'h02);
    repeat (3) tick();
    total++;
    if ({valid, wr_rd, addr, wdata, req_ready, rsp_valid, rsp_rdata, grant_id, err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {valid, wr_rd, addr, wdata, req_ready, rsp_valid, rsp_rdata, grant_id, err});
    end
    rst = 1'b1;
    tick();
    total++;
    if (valid !== 1'b1 || grant_id !== 2'd0 || addr !== 8'h11) begin
      bad++;
      $display("FAIL reset_first_grant got valid=%b gid=%0d addr=%h want 1/0/11", valid, grant_id, addr);
    end
  endtask

  task automatic test_fairness();
    logic prev_v;
    int   exp_g;
    set_req(0, 1'b1, 8'h01, 8'hA0);
    set_req(1, 1'b1, 8'h02, 8'hB0);
    ready  = 1'b1;
    prev_v = 1'b1;
    exp_g  = 1;
    for (int c = 0; c < 8; c++) begin
      tick();
      total++;
      if (valid !== !prev_v) begin
        bad++;
        $display("FAIL fair_valid cycle=%0d got=%b want=%b", c, valid, !prev_v);
      end
      if (valid === 1'b1) begin
        total++;
        if (grant_id !== 2'(exp_g)) begin
          bad++;
          $display("FAIL fair_grant cycle=%0d got=%0d want=%0d", c, grant_id, exp_g);
        end
        exp_g = 1 - exp_g;
      end
      prev_v = valid;
    end
    req_valid = 2'b00;
    tick();
    tick();
    ready = 1'b0;
  endtask

  task automatic test_read_path();
    bit ok;
    int vh;
    req_valid = 2'b10;
    set_req(1, 1'b0, 8'h05, 8'h00);
    ok = 0;
    for (int c = 0; c < 5 && !ok; c++) begin
      tick();
      if (valid === 1'b1) ok = 1;
    end
    total++;
    if (!ok || grant_id !== 2'd1 || addr !== 8'h05 || wr_rd !== 1'b0) begin
      bad++;
      $display("FAIL read_capture got seen=%0d gid=%0d addr=%h wr=%b want 1/1/05/0", ok, grant_id, addr, wr_rd);
    end
    vh = 1;
    repeat (3) begin
      tick();
      if (valid === 1'b1) vh++;
    end
    ready = 1'b1;
    rdata = 8'hA5;
    tick();
    total++;
    if (valid !== 1'b0 || req_ready !== 2'b10 || rsp_valid !== 2'b10 || rsp_rdata !== 8'hA5 || vh != 4) begin
      bad++;
      $display("FAIL read_done got valid=%b rr=%b rv=%b rd=%h vhigh=%0d want 0/10/10/a5/4",
               valid, req_ready, rsp_valid, rsp_rdata, vh);
    end
    ready = 1'b0;
    rdata = '0;
    req_valid = 2'b00;
    tick();
    total++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
      bad++;
      $display("FAIL read_pulse_len got rv=%b rr=%b want 00/00", rsp_valid, req_ready);
    end
  endtask

  task automatic test_write_path();
    bit ok;
    req_valid = 2'b01;
    set_req(0, 1'b1, 8'h10, 8'h3C);
    ok = 0;
    for (int c = 0; c < 5 && !ok; c++) begin
      tick();
      if (valid === 1'b1) ok = 1;
    end
    total++;
    if (!ok || grant_id !== 2'd0 || wr_rd !== 1'b1 || addr !== 8'h10 || wdata !== 8'h3C) begin
      bad++;
      $display("FAIL write_capture got seen=%0d gid=%0d wr=%b addr=%h wd=%h want 1/0/1/10/3c",
               ok, grant_id, wr_rd, addr, wdata);
    end
    // Committed: later requester-side changes must not reach the memory port.
    set_req(0, 1'b0, 8'h77, 8'hFF);
    repeat (2) begin
      tick();
      total++;
      if (valid !== 1'b1 || wr_rd !== 1'b1 || addr !== 8'h10 || wdata !== 8'h3C) begin
        bad++;
        $display("FAIL write_hold got valid=%b wr=%b addr=%h wd=%h want 1/1/10/3c", valid, wr_rd, addr, wdata);
      end
    end
    ready = 1'b1;
    tick();
    total++;
    if (valid !== 1'b0 || req_ready !== 2'b01 || rsp_valid !== 2'b00 || rsp_rdata !== 8'hA5) begin
      bad++;
      $display("FAIL write_done got valid=%b rr=%b rv=%b rd=%h want 0/01/00/a5",
               valid, req_ready, rsp_valid, rsp_rdata);
    end
    ready = 1'b0;
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    req_valid = 2'b10;
    set_req(1, 1'b0, 8'h33, 8'h00);
    ok = 0;
    for (int c = 0; c < 5 && !ok; c++) begin
      tick();
      if (valid === 1'b1) ok = 1;
    end
    total++;
    if (!ok || grant_id !== 2'd1) begin
      bad++;
      $display("FAIL rstmid_busy got seen=%0d gid=%0d want 1/1", ok, grant_id);
    end
    #3;
    rst = 1'b0;
    req_valid = 2'b11;
    set_req(0, 1'b1, 8'h44, 8'h55);
    #1;
    total++;
    if (valid !== 1'b0 || grant_id !== 2'd0 || req_ready !== 2'b00) begin
      bad++;
      $display("FAIL rstmid_async got valid=%b gid=%0d rr=%b want 0/0/00", valid, grant_id, req_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    total++;
    if (valid !== 1'b1 || grant_id !== 2'd0 || addr !== 8'h44) begin
      bad++;
      $display("FAIL rstmid_regrant got valid=%b gid=%0d addr=%h want 1/0/44", valid, grant_id, addr);
    end
    ready = 1'b1;
    rdata = 8'h9E;
    tick();
    req_valid = 2'b10;
    tick();
    total++;
    if (valid !== 1'b1 || grant_id !== 2'd1 || addr !== 8'h33) begin
      bad++;
      $display("FAIL rstmid_pending got valid=%b gid=%0d addr=%h want 1/1/33", valid, grant_id, addr);
    end
    tick();
    total++;
    if (rsp_valid !== 2'b10 || rsp_rdata !== 8'h9E) begin
      bad++;
      $display("FAIL rstmid_read got rv=%b rd=%h want 10/9e", rsp_valid, rsp_rdata);
    end
    req_valid = 2'b00;
    ready = 1'b0;
    rdata = '0;
    tick();
    last_m = 1;  // requester 1 was the last one served above
  endtask

  task automatic test_random();
    txn_t          t;
    bit            hs, busy_m, just_done, done, hs_wr;
    int            cur_g, exp_g, wait_cnt, idle_run, cyc;
    logic [DW-1:0] exp_rd;
    logic [N-1:0]  oh, exp_rv;
    for (int a = 0; a < (1 << AW); a++) mem[a] = DW'($urandom);
    cur_g = 0;
    exp_rd = '0;
    hs_wr = 0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        int len;
        len = $urandom_range(0, 6);
        for (int j = 0; j < len; j++) begin
          t.wr = 1'($urandom);
          t.a  = AW'($urandom_range(0, 7));
          t.d  = DW'($urandom);
          qs[i].push_back(t);
        end
      end
      busy_m = 0; just_done = 0; idle_run = 0; wait_cnt = 0; cyc = 0; done = 0;
      while (!done) begin
        for (int i = 0; i < N; i++) begin
          req_valid[i] = (qs[i].size() > 0);
          if (qs[i].size() > 0) set_req(i, qs[i][0].wr, qs[i][0].a, qs[i][0].d);
        end
        if (valid === 1'b1 && wait_cnt >= 2) ready = 1'b1;
        else ready = 1'($urandom_range(0, 1));
        rdata = mem[addr];
        hs = (valid === 1'b1) && ready;
        wait_cnt = (valid === 1'b1 && !ready) ? wait_cnt + 1 : 0;
        if (hs && busy_m && qs[cur_g].size() > 0) begin
          t      = qs[cur_g][0];
          exp_rd = mem[t.a];
          hs_wr  = t.wr;
          if (t.wr) mem[t.a] = t.d;
        end
        tick();
        cyc++;
        oh = '0;
        oh[cur_g] = 1'b1;
        if (hs) begin
          exp_rv = hs_wr ? '0 : oh;
          total++;
          if (valid !== 1'b0 || req_ready !== oh || rsp_valid !== exp_rv || err !== 1'b0) begin
            bad++;
            $display("FAIL rnd_done got valid=%b rr=%b rv=%b err=%b want 0/%b/%b/0",
                     valid, req_ready, rsp_valid, err, oh, exp_rv);
          end
          if (!hs_wr) begin
            total++;
            if (rsp_rdata !== exp_rd) begin
              bad++;
              $display("FAIL rnd_rdata got=%h want=%h", rsp_rdata, exp_rd);
            end
          end
          if (qs[cur_g].size() > 0) void'(qs[cur_g].pop_front());
          last_m = cur_g; busy_m = 0; just_done = 1; idle_run = 1;
        end else if (busy_m) begin
          if (qs[cur_g].size() > 0) t = qs[cur_g][0];
          total++;
          if (valid !== 1'b1 || grant_id !== 2'(cur_g) || wr_rd !== t.wr || addr !== t.a ||
              (t.wr && wdata !== t.d) || req_ready !== '0) begin
            bad++;
            $display("FAIL rnd_hold got valid=%b gid=%0d wr=%b addr=%h wd=%h want 1/%0d/%b/%h/%h",
                     valid, grant_id, wr_rd, addr, wdata, cur_g, t.wr, t.a, t.d);
          end
        end else if (valid === 1'b1) begin
          exp_g = rr_pick(last_m);
          total++;
          if (exp_g < 0 || grant_id !== 2'(exp_g)) begin
            bad++;
            $display("FAIL rnd_grant got=%0d want=%0d", grant_id, exp_g);
          end else begin
            t = qs[exp_g][0];
            total++;
            if (wr_rd !== t.wr || addr !== t.a || (t.wr && wdata !== t.d)) begin
              bad++;
              $display("FAIL rnd_payload got wr=%b addr=%h wd=%h want %b/%h/%h", wr_rd, addr, wdata, t.wr, t.a, t.d);
            end
            if (exp_g == last_m) begin
              total++;
              if (just_done) begin
                bad++;
                $display("FAIL rnd_mask got regrant=1 want regrant=0 for requester %0d", exp_g);
              end
            end
          end
          cur_g = (exp_g < 0) ? 0 : exp_g;
          busy_m = 1; just_done = 0; idle_run = 0;
        end else begin
          idle_run++;
          just_done = 0;
          total++;
          if (req_ready !== '0 || rsp_valid !== '0 || err !== 1'b0 || (rr_pick(last_m) >= 0 && idle_run > 2)) begin
            bad++;
            $display("FAIL rnd_idle got rr=%b rv=%b err=%b idle=%0d want 0/0/0/<=2", req_ready, rsp_valid, err, idle_run);
          end
          done = (rr_pick(last_m) < 0);
        end
        if (cyc >= 1000) begin
          bad++;
          total++;
          $display("FAIL rnd_budget got cycles=%0d want <1000", cyc);
          for (int i = 0; i < N; i++) qs[i].delete();
          done = 1;
        end
      end
    end
    req_valid = '0;
    ready = 1'b0;
    tick();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit           ok;
    int           g0;
    logic [N-1:0] oh;
    g0 = (last_m + 1) % N;
    oh = '0;
    oh[g0] = 1'b1;
    ready = 1'b0;
    req_valid = 2'b11;
    set_req(0, 1'b0, 8'h01, 8'h00);
    set_req(1, 1'b0, 8'h02, 8'h00);
    ok = 0;
    for (int c = 0; c < 5 && !ok; c++) begin
      tick();
      if (valid === 1'b1) ok = 1;
    end
    total++;
    if (!ok || grant_id !== 2'(g0)) begin
      bad++;
      $display("FAIL to_grant got seen=%0d gid=%0d want 1/%0d", ok, grant_id, g0);
    end
    repeat (3) begin
      tick();
      total++;
      if (err !== 1'b0 || valid !== 1'b1) begin
        bad++;
        $display("FAIL to_wait got err=%b valid=%b want 0/1", err, valid);
      end
    end
    tick();
    total++;
    if (err !== 1'b1 || req_ready !== oh || rsp_valid !== '0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL to_abort got err=%b rr=%b rv=%b valid=%b want 1/%b/0/0", err, req_ready, rsp_valid, valid, oh);
    end
    tick();
    total++;
    if (valid !== 1'b1 || grant_id !== 2'(1 - g0)) begin
      bad++;
      $display("FAIL to_next got valid=%b gid=%0d want 1/%0d", valid, grant_id, 1 - g0);
    end
    req_valid = '0;
    ready = 1'b1;
    tick();
    tick();
    ready = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_wr_rd = '0;
    req_addr = '0;
    req_wdata = '0;
    ready = 1'b0;
    rdata = '0;
    last_m = 1;
    test_reset();
    test_fairness();
    test_read_path();
    test_write_path();
    test_reset_mid();
    test_random();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
